// File: rtl/gl_fetch_stream.sv
// Instruction-stream fetch unit: BRAM reads, opcode/operand tagging, 2-entry skid buffer, redirect.
// Optional halt opcode (0xFF) is enabled by defining GL_FETCH_HALT_EN.
module gl_fetch_stream #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_START = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int IDX_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_rd_en,
    input  logic [DATA_WIDTH-1:0] inst_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_word,
    output logic                  out_opcode,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  out_last,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  halted
);

    localparam int EW = DATA_WIDTH + IDX_WIDTH + 2;
    localparam logic [EW-1:0] RESET_ENTRY = {RESET_VALUE, 1'b0, {IDX_WIDTH{1'b0}}, 1'b0};

    function automatic logic [IDX_WIDTH-1:0] operand_count(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      operand_count = IDX_WIDTH'(3);
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: operand_count = IDX_WIDTH'(16);
            8'h19:                             operand_count = IDX_WIDTH'(4);
            8'h1A:                             operand_count = IDX_WIDTH'(6);
            default:                           operand_count = '0;
        endcase
    endfunction

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  inflight_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_mid;
    logic [1:0]            occ_next;
    logic [EW-1:0]         entry_reg [2];
    logic [EW-1:0]         entry_next [2];
    logic [EW-1:0]         new_entry;
    logic [IDX_WIDTH-1:0]  count_reg;
    logic [IDX_WIDTH-1:0]  count_next;
    logic [IDX_WIDTH-1:0]  total_reg;
    logic [IDX_WIDTH-1:0]  total_next;
    logic [IDX_WIDTH-1:0]  op_cnt;
    logic [2:0]            level;
    logic                  pop;
    logic                  issue;
    logic                  halt_block;

`ifdef GL_FETCH_HALT_EN
    logic halted_reg;
    logic halt_now;

    // A halt opcode on the return path already blocks the read that would follow it.
    assign halt_now   = inflight_reg && (count_reg == '0) && (inst_in[7:0] == 8'hFF);
    assign halt_block = halted_reg || halt_now;
    assign halted     = halted_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_reg <= 1'b0;
        end else if (redirect_valid) begin
            halted_reg <= 1'b0;
        end else if (halt_now) begin
            halted_reg <= 1'b1;
        end
    end
`else
    assign halt_block = 1'b0;
    assign halted     = 1'b0;
`endif

    assign out_valid = (occ_reg != 2'd0);
    assign {out_word, out_opcode, out_index, out_last} = entry_reg[0];
    assign pop = out_valid && out_ready;

    // Slots committed after this edge: buffered words plus the pending return, minus the one leaving.
    assign level      = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue      = reset && !redirect_valid && !halt_block && (level < 3'd2);
    assign inst_rd_en = issue;
    assign inst_addr  = addr_reg;

    always_comb begin
        op_cnt     = operand_count(inst_in[7:0]);
        new_entry  = '0;
        count_next = count_reg;
        total_next = total_reg;
        if (count_reg == '0) begin
            new_entry  = {inst_in, 1'b1, {IDX_WIDTH{1'b0}}, (op_cnt == '0)};
            count_next = op_cnt;
            total_next = op_cnt;
        end else begin
            new_entry  = {inst_in, 1'b0, total_reg - count_reg + IDX_WIDTH'(1),
                          (count_reg == IDX_WIDTH'(1))};
            count_next = count_reg - IDX_WIDTH'(1);
        end
    end

    always_comb begin
        entry_next[0] = entry_reg[0];
        entry_next[1] = entry_reg[1];
        occ_mid       = occ_reg;
        if (pop) begin
            entry_next[0] = entry_reg[1];
            occ_mid       = occ_reg - 2'd1;
        end
        if (inflight_reg) begin
            if (occ_mid == 2'd0) begin
                entry_next[0] = new_entry;
            end else begin
                entry_next[1] = new_entry;
            end
        end
        occ_next = occ_mid + {1'b0, inflight_reg};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg      <= TEXT_START;
            inflight_reg  <= 1'b0;
            occ_reg       <= 2'd0;
            entry_reg[0]  <= RESET_ENTRY;
            entry_reg[1]  <= RESET_ENTRY;
            count_reg     <= '0;
            total_reg     <= '0;
        end else if (redirect_valid) begin
            addr_reg      <= redirect_addr;
            inflight_reg  <= 1'b0;
            occ_reg       <= 2'd0;
            count_reg     <= '0;
            total_reg     <= '0;
        end else begin
            if (issue) begin
                addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
            inflight_reg <= issue;
            occ_reg      <= occ_next;
            entry_reg[0] <= entry_next[0];
            entry_reg[1] <= entry_next[1];
            if (inflight_reg) begin
                count_reg <= count_next;
                total_reg <= total_next;
            end
        end
    end

endmodule

// File: tb/tb_gl_fetch_stream.sv
// Self-checking bench for gl_fetch_stream: directed scenarios plus random handshake/redirect,
// every delivered word checked against a command-parsing reference model of the BRAM contents.
module tb_gl_fetch_stream;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int MEM_SIZE = 256;
    localparam logic [DW-1:0] RV = 32'hA5A5_0F0F;

    logic          clk;
    logic          reset;
    logic [AW-1:0] inst_addr;
    logic          inst_rd_en;
    logic [DW-1:0] inst_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_word;
    logic          out_opcode;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          halted;

    gl_fetch_stream #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TEXT_START ('0),
        .RESET_VALUE(RV),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_addr     (inst_addr),
        .inst_rd_en    (inst_rd_en),
        .inst_in       (inst_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_word      (out_word),
        .out_opcode    (out_opcode),
        .out_index     (out_index),
        .out_last      (out_last),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [MEM_SIZE];
    always @(posedge clk) if (inst_rd_en) inst_in <= mem[inst_addr];

    int n_checks = 0;
    int n_fails  = 0;
    int n_words  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks memory as a command stream from the last restart address.
    function automatic int op_count(input logic [7:0] op);
        case (op)
            8'h03, 8'h04: return 3;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 16;
            8'h19: return 4;
            8'h1A: return 6;
            default: return 0;
        endcase
    endfunction

    int m_addr;
    int m_pos;
    int m_len;
    bit m_halted;

    task automatic model_restart(input int a);
        m_addr = a % MEM_SIZE;
        m_pos = 0;
        m_len = 0;
        m_halted = 1'b0;
    endtask

    task automatic model_next(output logic [DW+IW+1:0] e);
        logic [DW-1:0] w;
        w = mem[m_addr];
        m_addr = (m_addr + 1) % MEM_SIZE;
        if (m_pos == m_len) begin
            m_len = op_count(w[7:0]);
            m_pos = 0;
            e = {w, 1'b1, IW'(0), (m_len == 0)};
`ifdef GL_FETCH_HALT_EN
            if (w[7:0] == 8'hFF) m_halted = 1'b1;
`endif
        end else begin
            m_pos++;
            e = {w, 1'b0, IW'(m_pos), (m_pos == m_len)};
        end
    endtask

    task automatic drive(input bit rdy, input bit redir, input logic [AW-1:0] raddr);
        out_ready = rdy;
        redirect_valid = redir;
        redirect_addr = raddr;
        #1;
    endtask

    // Checks any word accepted this cycle, applies redirect to the model, moves to the next cycle.
    task automatic finish_cycle();
        logic [DW+IW+1:0] e;
        if (out_valid && out_ready) begin
            if (m_halted) begin
                check("word_after_halt", {63'd0, out_valid & out_ready}, 64'd0);
            end else begin
                model_next(e);
                check("xfer", {out_word, out_opcode, out_index, out_last}, e);
            end
            $display("xfer %0d word=%h opcode=%0d index=%0d last=%0d",
                     n_words, out_word, out_opcode, out_index, out_last);
            n_words++;
        end
        if (redirect_valid) model_restart(int'(redirect_addr));
        @(negedge clk);
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [AW-1:0] raddr);
        drive(rdy, redir, raddr);
        finish_cycle();
    endtask

    task automatic gen_program();
        int a;
        int n;
        logic [DW-1:0] r;
        logic [7:0] ops [13];
        ops = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h22, 8'h7F};
        a = 0;
        while (a < MEM_SIZE) begin
            r = $urandom();
            r[7:0] = ops[$urandom_range(0, 12)];
            mem[a] = r;
            a++;
            n = op_count(r[7:0]);
            for (int i = 0; i < n; i++) begin
                r = $urandom();
                if (r[7:0] == 8'hFF) r[7:0] = 8'h00;
                mem[a % MEM_SIZE] = r;
                a++;
            end
        end
    endtask

    initial begin
        logic [6:0] vbits;
        logic [AW-1:0] frozen;
        int base;
        reset = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        gen_program();
        mem[0] = 32'h0000_0003; mem[1] = 32'd1; mem[2] = 32'd2; mem[3] = 32'd3; mem[4] = 32'h0000_0000;
        mem[8'h10] = 32'h1234_5613;
        for (int i = 1; i <= 16; i++) mem[8'h10 + i] = 32'h0B00_0000 + i;
        mem[8'h30] = 32'h0000_0016;
        for (int i = 1; i <= 16; i++) mem[8'h30 + i] = 32'h0C00_0000 + i;
        mem[8'h20] = 32'hCAFE_0011;
        for (int i = 1; i <= 16; i++) mem[8'h20 + i] = 32'h0D00_0000 + i;
        mem[8'h40] = 32'hBEEF_0019;
        mem[8'hFD] = 32'h0000_0022; mem[8'hFE] = 32'h0000_0003;
        mem[8'hFF] = 32'h0E00_0001; mem[8'h00] = 32'h0000_0003;
        mem[0] = 32'h0000_0003;
        mem[8'h80] = 32'h0000_0004; mem[8'h81] = 32'hA; mem[8'h82] = 32'hB; mem[8'h83] = 32'hC;
        mem[8'h84] = 32'h0000_00FF; mem[8'h85] = 32'h0000_0003;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_inst_addr", 64'(inst_addr), 64'd0);
        check("rst_rd_en", 64'(inst_rd_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word", 64'(out_word), 64'(RV));
        check("rst_tags", {61'd0, out_opcode, out_last, |out_index}, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // A: short command then zero-operand opcode, out_ready held high
        reset = 1'b1;
        model_restart(0);
        vbits = '0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, '0);
            if (c < 7) vbits[c] = out_valid;
            if (c == 0) check("a_first_issue", {55'd0, inst_rd_en, inst_addr}, {55'd0, 1'b1, 8'h00});
            if (c == 5) check("a_addr_5", 64'(inst_addr), 64'd5);
            finish_cycle();
        end
        check("a_valid_cycles", 64'(vbits), 64'(7'b1111100));

        // B: 0x13 with 16 operands, out_ready toggling
        step(1'b0, 1'b1, 8'h10);
        base = n_words;
        for (int c = 0; c < 40; c++) step(c[0], 1'b0, '0);
        check("b_word_count_ge17", 64'(n_words - base >= 17), 64'd1);

        // C: stall for 10 cycles mid-stream, then resume
        step(1'b0, 1'b1, 8'h30);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, '0);
        frozen = '0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, '0);
            if (c == 3) frozen = inst_addr;
            if (c >= 3) begin
                check("c_stall_rd_en", 64'(inst_rd_en), 64'd0);
                check("c_stall_valid", 64'(out_valid), 64'd1);
                check("c_stall_addr", 64'(inst_addr), 64'(frozen));
            end
            finish_cycle();
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, '0);
            check("c_resume_valid", 64'(out_valid), 64'd1);
            finish_cycle();
        end

        // D: redirect to 0x40 in the middle of a 0x11 operand run
        step(1'b0, 1'b1, 8'h20);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 8'h40);
        check("d_redirect_rd_en", 64'(inst_rd_en), 64'd0);
        finish_cycle();
        drive(1'b1, 1'b0, '0);
        check("d_valid_low_1", 64'(out_valid), 64'd0);
        check("d_addr_loaded", {55'd0, inst_rd_en, inst_addr}, {55'd0, 1'b1, 8'h40});
        finish_cycle();
        drive(1'b1, 1'b0, '0);
        check("d_valid_low_2", 64'(out_valid), 64'd0);
        finish_cycle();
        drive(1'b1, 1'b0, '0);
        check("d_first_word", {out_valid, out_word, out_opcode, out_index},
              {1'b1, mem[8'h40], 1'b1, IW'(0)});
        finish_cycle();
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0);

        // E: address wrap from 0xFF to 0x00
        step(1'b0, 1'b1, 8'hFD);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, '0);
            if (c == 3) check("e_wrap_addr", 64'(inst_addr), 64'd0);
            finish_cycle();
        end

        // F: halt opcode behaviour
        step(1'b0, 1'b1, 8'h80);
        base = n_words;
        for (int c = 0; c < 12; c++) step(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
`ifdef GL_FETCH_HALT_EN
        check("f_halted", 64'(halted), 64'd1);
        check("f_addr_stopped", 64'(inst_addr), 64'h85);
        check("f_rd_en_low", 64'(inst_rd_en), 64'd0);
        check("f_words", 64'(n_words - base), 64'd5);
        finish_cycle();
        step(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, '0);
        check("f_halt_cleared", 64'(halted), 64'd0);
        finish_cycle();
`else
        check("f_halted_tied", 64'(halted), 64'd0);
        check("f_words", 64'(n_words - base), 64'd10);
        finish_cycle();
`endif

        // Random handshake and redirects
        base = n_words;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) step(1'b0, 1'b1, AW'($urandom_range(0, MEM_SIZE - 1)));
            else step($urandom_range(0, 3) != 0, 1'b0, '0);
        end
        check("rand_progress", 64'(n_words - base > 100), 64'd1);

        // Reset in the middle of a command
        step(1'b0, 1'b1, 8'h20);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, '0);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {out_valid, inst_rd_en, inst_addr, out_word},
              {1'b0, 1'b0, 8'h00, RV});
        @(negedge clk);
        reset = 1'b1;
        model_restart(0);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        check("mid_rst_resume_addr", 64'(inst_addr), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gl_fetch_stream.md
# gl_fetch_stream

Parametrised instruction-stream fetch unit for the GL command processor, successor to the fixed-stride fetch stage. Reads command words from a synchronous-read instruction BRAM, tags each word as opcode or operand (with operand index and last flag) from a per-opcode operand-count table, and delivers them to decode over a valid/ready handshake through a 2-entry skid buffer. Also provides address redirect (display-list call/loop) and an optional halt opcode.

## Interface
- ADDR_WIDTH, 32, width of inst_addr and redirect_addr
- DATA_WIDTH, 32, command word width (opcode in bits [7:0])
- TEXT_START, 0, fetch address after reset
- RESET_VALUE, 0, reset value of out_word
- IDX_WIDTH, 5, width of out_index (covers 0..16)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- inst_addr  out  ADDR_WIDTH  BRAM read address
- inst_rd_en  out  1  BRAM read enable; inst_in holds mem[inst_addr] the cycle after
- inst_in  in  DATA_WIDTH  BRAM read data
- out_valid  out  1  out_* fields hold a word
- out_ready  in  1  decode accepts word when out_valid && out_ready
- out_word  out  DATA_WIDTH  command word
- out_opcode  out  1  word is an opcode
- out_index  out  IDX_WIDTH  0 for opcode; 1..N for operand n
- out_last  out  1  final word of the command
- redirect_valid  in  1  load redirect_addr and flush
- redirect_addr  in  ADDR_WIDTH  new fetch address
- halted  out  1  fetch stopped on halt opcode (GL_FETCH_HALT_EN only)

## Operation
- Operand counts by opcode [7:0]: 0x03→3, 0x04→3, 0x11→16, 0x13→16, 0x16→16, 0x17→16, 0x18→16, 0x19→4, 0x1A→6, all others→0.
- Reset: inst_addr=TEXT_START, inst_rd_en=0, out_valid=0, out_word=RESET_VALUE, out_opcode/out_index/out_last=0, halted=0, buffer empty, operand counter 0, no read in flight.
- Read issue: inst_rd_en=1 this cycle iff (occupancy + inflight − pop) < 2, where pop = out_valid && out_ready; on issue inst_addr increments by 1 at the edge, wrapping 2^ADDR_WIDTH−1 → 0.
- Return: one cycle after issue, inst_in is always written to the buffer tail (never dropped unless flushed).
- Tagging at write: counter==0 → opcode, index 0, counter loaded from table, last = (count==0). Counter>0 → operand, index = table_count − counter + 1, counter decrements, last = (counter==1).
- Buffer: FIFO order; head drives out_*. Simultaneous write and pop allowed at occupancy 1 or 2.
- Redirect (highest priority): at edge, inst_addr←redirect_addr, buffer cleared, counter cleared, in-flight return discarded, halted cleared; inst_rd_en=0 in that cycle; issue resumes next cycle.
- Reset mid-command: all state to reset values immediately; partial command is abandoned.

## Timing
- Reset/redirect release to first out_valid: 2 cycles (issue, return).
- Sustained throughput with out_ready=1: one word per cycle.
- out_valid and fields are registered; no combinational path from out_ready to out_*; inst_rd_en depends combinationally on out_ready.
- With out_ready=0, at most 2 words buffered; inst_rd_en deasserts; no word lost or duplicated.

## Configuration
- GL_FETCH_HALT_EN defined: opcode 0xFF (count 0) tagged as opcode, delivered, then halted=1 from the edge it is written and no further reads issue until redirect_valid or reset. Words already in flight are still delivered.
- Undefined: 0xFF is an ordinary zero-operand opcode; halted tied 0.

## Test plan
- Reset then mem[0]=0x03,1,2,3,mem[4]=0x00, out_ready=1: words at cycles 2..6, tags (op,0,0),(arg,1,0),(arg,2,0),(arg,3,1),(op,0,1); inst_addr reaches 5.
- Opcode 0x13 + 16 operands with out_ready toggled 1/0 each cycle: 17 words in order, indices 0..16, out_last only on index 16, none lost/duplicated.
- out_ready=0 for 10 cycles mid-stream: occupancy saturates at 2, inst_rd_en low, inst_addr frozen; resumes at 1 word/cycle.
- redirect_valid at addr 0x40 mid-0x11 operand stream: in-flight word discarded, out_valid low next cycle, mem[0x40] delivered 2 cycles later tagged opcode index 0.
- inst_addr at 2^ADDR_WIDTH−1 with ADDR_WIDTH=4: next issued address 0.
- GL_FETCH_HALT_EN: 0x04,a,b,c,0xFF,0x03: 0xFF delivered with out_last=1, halted=1, 0x03 never read until redirect.
